// File: rtl/cbfp_pkg.sv
// Shared CBFP constants and sample/exponent types, used by the normalizer and denormalizer.
package cbfp_pkg;

    localparam int NCHAN      = 16;
    localparam int IN_W       = 11;
    localparam int OUT_W      = 23;
    localparam int EXP_W      = 6;
    localparam int BASE_SHIFT = 12;
    localparam int BLK_BEATS  = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int NET_W      = EXP_W + 1;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    typedef logic signed [IN_W-1:0]  in_samp_t;
    typedef logic signed [OUT_W-1:0] out_samp_t;
    typedef logic signed [EXP_W-1:0] exp_t;
    typedef logic signed [NET_W-1:0] net_t;

    typedef in_samp_t  in_vec_t  [NCHAN];
    typedef out_samp_t out_vec_t [NCHAN];

    // Net left shift for a block exponent, limited to what an OUT_W sample can express.
    function automatic net_t net_shift(input exp_t e);
        net_t n;
        n = net_t'(BASE_SHIFT) - net_t'(e);
        if (n > net_t'(OUT_W - 1))
            n = net_t'(OUT_W - 1);
        else if (n < -net_t'(OUT_W - 1))
            n = -net_t'(OUT_W - 1);
        return n;
    endfunction

endpackage

// File: rtl/cbfp_exp_fifo.sv
// Small synchronous FIFO holding block exponents until their data block starts.
module cbfp_exp_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO still lands when the head leaves on the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; entries are only ever read after being written, so a reset adds cost for nothing.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/cbfp_denorm_module.sv
// CBFP denormalizer: re-expands reduced-width samples using a per-block exponent, with saturation.
module cbfp_denorm_module
    import cbfp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             exp_valid,
    input  exp_t             exp_in,
    input  logic             valid_in,
    input  in_vec_t          data_re_in,
    input  in_vec_t          data_im_in,
    output out_vec_t         data_re_out,
    output out_vec_t         data_im_out,
    output logic             valid_out,
    output logic             sat_out,
    output logic [LVL_W-1:0] fifo_level,
    output logic             err_ovf,
    output logic             err_unf
);

    localparam int CNT_W  = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
    localparam int WIDE_W = 2 * OUT_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLK_BEATS - 1);
    localparam logic signed [WIDE_W-1:0] SAT_HI = (WIDE_W'(1) <<< (OUT_W - 1)) - WIDE_W'(1);
    localparam logic signed [WIDE_W-1:0] SAT_LO = ~SAT_HI;

    logic [CNT_W-1:0] beat_cnt;
    exp_t             cur_exp;
    exp_t             fifo_head;
    exp_t             beat_exp;
    logic             fifo_full;
    logic             fifo_empty;
    logic             blk_start;
    logic             bypass;
    logic             do_pop;
    logic             push_req;
    logic             drop;

    assign blk_start = valid_in && (beat_cnt == '0);
    assign bypass    = blk_start && fifo_empty && exp_valid;
    assign do_pop    = blk_start && !fifo_empty;
    assign push_req  = exp_valid && !bypass;
    assign drop      = push_req && fifo_full && !do_pop;

    cbfp_exp_fifo #(
        .WIDTH (EXP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_exp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (do_pop),
        .din   (exp_in),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        beat_exp = cur_exp;
        if (blk_start) begin
            if (!fifo_empty)
                beat_exp = fifo_head;
            else if (exp_valid)
                beat_exp = exp_in;
            else
                beat_exp = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            cur_exp  <= '0;
            err_ovf  <= 1'b0;
            err_unf  <= 1'b0;
        end else begin
            if (valid_in)
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
            if (blk_start)
                cur_exp <= beat_exp;
            if (drop)
                err_ovf <= 1'b1;
            if (blk_start && fifo_empty && !exp_valid)
                err_unf <= 1'b1;
        end
    end

    // Stage 1: sign-extended samples and the net shift for this beat.
    logic     s1_valid;
    net_t     s1_net;
    out_vec_t s1_re;
    out_vec_t s1_im;

    always_ff @(posedge clk) begin
        if (rst)
            s1_valid <= 1'b0;
        else
            s1_valid <= valid_in;
    end

    always_ff @(posedge clk) begin
        if (valid_in) begin
            s1_net <= net_shift(beat_exp);
            for (int i = 0; i < NCHAN; i++) begin
                s1_re[i] <= out_samp_t'(data_re_in[i]);
                s1_im[i] <= out_samp_t'(data_im_in[i]);
            end
        end
    end

    // Stage 2: shift by the net amount, clamping left shifts that leave the output range.
    net_t             neg_net;
    logic             shift_left;
    logic [NET_W-2:0] shift_amt;
    out_vec_t         sh_re;
    out_vec_t         sh_im;
    logic [NCHAN-1:0] sat_re;
    logic [NCHAN-1:0] sat_im;

    assign neg_net    = -s1_net;
    assign shift_left = !s1_net[NET_W-1];
    assign shift_amt  = shift_left ? s1_net[NET_W-2:0] : neg_net[NET_W-2:0];

    function automatic out_samp_t shift_sat(
        input  out_samp_t        x,
        input  logic             left,
        input  logic [NET_W-2:0] amt,
        output logic             sat
    );
        logic signed [WIDE_W-1:0] wide;
        wide = WIDE_W'(x);
        if (left)
            wide = wide <<< amt;
        else
            wide = wide >>> amt;
        sat = 1'b0;
        if (wide > SAT_HI) begin
            wide = SAT_HI;
            sat  = 1'b1;
        end else if (wide < SAT_LO) begin
            wide = SAT_LO;
            sat  = 1'b1;
        end
        return out_samp_t'(wide);
    endfunction

    for (genvar i = 0; i < NCHAN; i++) begin : g_lane
        out_samp_t lane_re;
        out_samp_t lane_im;
        logic      lane_sat_re;
        logic      lane_sat_im;

        always_comb begin
            lane_sat_re = 1'b0;
            lane_sat_im = 1'b0;
            lane_re     = shift_sat(s1_re[i], shift_left, shift_amt, lane_sat_re);
            lane_im     = shift_sat(s1_im[i], shift_left, shift_amt, lane_sat_im);
        end

        assign sh_re[i]  = lane_re;
        assign sh_im[i]  = lane_im;
        assign sat_re[i] = lane_sat_re;
        assign sat_im[i] = lane_sat_im;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out   <= 1'b0;
            sat_out     <= 1'b0;
            data_re_out <= '{default: '0};
            data_im_out <= '{default: '0};
        end else begin
            valid_out <= s1_valid;
            sat_out   <= s1_valid && (|{sat_re, sat_im});
            if (s1_valid) begin
                data_re_out <= sh_re;
                data_im_out <= sh_im;
            end
        end
    end

endmodule

// File: tb/tb_cbfp_denorm_module.sv
// Scoreboard bench for cbfp_denorm_module: a queue-based exponent model predicts every output beat.
module tb_cbfp_denorm_module;
    import cbfp_pkg::*;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             exp_valid = 1'b0;
    logic             valid_in  = 1'b0;
    exp_t             exp_in    = '0;
    in_vec_t          data_re_in;
    in_vec_t          data_im_in;
    out_vec_t         data_re_out;
    out_vec_t         data_im_out;
    logic             valid_out;
    logic             sat_out;
    logic [LVL_W-1:0] fifo_level;
    logic             err_ovf;
    logic             err_unf;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    typedef struct {
        longint re [NCHAN];
        longint im [NCHAN];
        bit     sat;
        longint due;
    } beat_t;

    beat_t  sb [$];
    beat_t  mb;
    int     mk;

    int     m_q [$];
    int     m_cnt = 0;
    int     m_cur = 0;
    bit     m_ovf = 0;
    bit     m_unf = 0;
    int     re_buf [NCHAN];
    int     im_buf [NCHAN];

    cbfp_denorm_module dut (
        .clk         (clk),
        .rst         (rst),
        .exp_valid   (exp_valid),
        .exp_in      (exp_in),
        .valid_in    (valid_in),
        .data_re_in  (data_re_in),
        .data_im_in  (data_im_in),
        .data_re_out (data_re_out),
        .data_im_out (data_im_out),
        .valid_out   (valid_out),
        .sat_out     (sat_out),
        .fifo_level  (fifo_level),
        .err_ovf     (err_ovf),
        .err_unf     (err_unf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Value of x * 2^(BASE_SHIFT - e), floored, then limited to the signed OUT_W range.
    function automatic longint ref_scale(input longint x, input int e, output bit s);
        int     net;
        longint v;
        longint d;
        longint hi;
        longint lo;
        net = BASE_SHIFT - e;
        if (net > OUT_W - 1)    net = OUT_W - 1;
        if (net < -(OUT_W - 1)) net = -(OUT_W - 1);
        if (net >= 0) begin
            v = x * (longint'(1) << net);
        end else begin
            d = longint'(1) << (-net);
            v = x / d;
            if ((x % d != 0) && (x < 0))
                v = v - 1;
        end
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        s  = 0;
        if (v > hi) begin v = hi; s = 1; end
        if (v < lo) begin v = lo; s = 1; end
        return v;
    endfunction

    // One clock of stimulus; the model is advanced for the same edge.
    task automatic drive(input bit ev, input int e, input bit vin);
        bit    blk;
        bit    bp;
        bit    s;
        beat_t b;
        exp_valid = ev;
        exp_in    = exp_t'(e);
        valid_in  = vin;
        for (int i = 0; i < NCHAN; i++) begin
            data_re_in[i] = in_samp_t'(re_buf[i]);
            data_im_in[i] = in_samp_t'(im_buf[i]);
        end
        blk = vin && (m_cnt == 0);
        bp  = blk && (m_q.size() == 0) && ev;
        if (blk) begin
            if (m_q.size() != 0) m_cur = m_q.pop_front();
            else if (ev)         m_cur = e;
            else begin           m_cur = 0; m_unf = 1; end
        end
        if (ev && !bp) begin
            if (m_q.size() < FIFO_DEPTH) m_q.push_back(e);
            else                         m_ovf = 1;
        end
        if (vin) begin
            b.sat = 0;
            for (int i = 0; i < NCHAN; i++) begin
                b.re[i] = ref_scale(re_buf[i], m_cur, s);
                b.sat   = b.sat | s;
                b.im[i] = ref_scale(im_buf[i], m_cur, s);
                b.sat   = b.sat | s;
            end
            b.due = cyc + 2;
            sb.push_back(b);
            m_cnt = (m_cnt + 1) % BLK_BEATS;
        end
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        valid_in  = 1'b0;
        check("fifo_level", fifo_level, m_q.size());
        check("err_ovf", err_ovf, m_ovf);
        check("err_unf", err_unf, m_unf);
    endtask

    task automatic set_bufs(input int r, input int im);
        for (int i = 0; i < NCHAN; i++) begin
            re_buf[i] = r;
            im_buf[i] = im;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    task automatic push_exp(input int e);
        drive(1, e, 0);
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1);
    endtask

    task automatic do_reset();
        longint nz_re;
        longint nz_im;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_q.delete();
        sb.delete();
        m_cnt = 0;
        m_cur = 0;
        m_ovf = 0;
        m_unf = 0;
        nz_re = 0;
        nz_im = 0;
        for (int i = 0; i < NCHAN; i++) begin
            if (data_re_out[i] != 0) nz_re = data_re_out[i];
            if (data_im_out[i] != 0) nz_im = data_im_out[i];
        end
        check("rst_valid_out", valid_out, 0);
        check("rst_sat_out", sat_out, 0);
        check("rst_level", fifo_level, 0);
        check("rst_err_ovf", err_ovf, 0);
        check("rst_err_unf", err_unf, 0);
        check("rst_data_re", nz_re, 0);
        check("rst_data_im", nz_im, 0);
    endtask

    // Monitor: every presented beat is matched against the oldest prediction.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_out) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: valid_out=1 while no beat was expected");
                end else begin
                    mb = sb.pop_front();
                    check("latency", cyc, mb.due);
                    mk = 0;
                    for (int i = NCHAN - 1; i >= 0; i--)
                        if (longint'(data_re_out[i]) != mb.re[i]) mk = i;
                    check($sformatf("re[%0d]", mk), data_re_out[mk], mb.re[mk]);
                    mk = 0;
                    for (int i = NCHAN - 1; i >= 0; i--)
                        if (longint'(data_im_out[i]) != mb.im[i]) mk = i;
                    check($sformatf("im[%0d]", mk), data_im_out[mk], mb.im[mk]);
                    check("sat_out", sat_out, mb.sat);
                end
            end else begin
                check("sat_idle", sat_out, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        set_bufs(0, 0);
        for (int i = 0; i < NCHAN; i++) begin
            data_re_in[i] = '0;
            data_im_in[i] = '0;
        end
        repeat (2) @(posedge clk);
        do_reset();

        // Identity scale, then a right shift.
        set_bufs(1, -1);
        push_exp(0);
        beats(4);
        idle(3);
        set_bufs(5, -5);
        push_exp(14);
        beats(4);
        idle(3);

        // Saturation in both directions on lane 0.
        set_bufs(0, 0);
        re_buf[0] = 1023;
        push_exp(-2);
        beats(4);
        re_buf[0] = -1024;
        push_exp(-2);
        beats(4);
        idle(3);

        // Queued exponents consumed across a gappy stream.
        push_exp(3);
        push_exp(0);
        push_exp(14);
        set_bufs(-8, 0);
        for (int j = 0; j < 12; j++) begin
            drive(0, 0, 1);
            if (j == 0) check("q_level_blk0", fifo_level, 2);
            if (j == 4) check("q_level_blk1", fifo_level, 1);
            if (j == 8) check("q_level_blk2", fifo_level, 0);
            if (j % 3 == 2) idle(1);
        end
        idle(3);
        do_reset();

        // Overflow: nine pushes into an eight-deep FIFO.
        for (int j = 0; j < 9; j++) push_exp(j);
        check("ovf_flag", err_ovf, 1);
        check("ovf_level", fifo_level, 8);
        do_reset();

        // Underflow: data with nothing queued.
        set_bufs(3, -3);
        beats(1);
        check("unf_flag", err_unf, 1);
        beats(3);
        idle(3);
        do_reset();

        // Bypass: exponent arrives with the first beat of the block.
        set_bufs(-8, 2);
        drive(1, 3, 1);
        check("bypass_level", fifo_level, 0);
        check("bypass_unf", err_unf, 0);
        beats(3);
        idle(3);
        do_reset();

        // Reset in the middle of a block.
        set_bufs(7, -7);
        push_exp(5);
        push_exp(7);
        beats(2);
        idle(3);
        do_reset();
        beats(1);
        check("mid_rst_unf", err_unf, 1);
        beats(3);
        idle(3);
        do_reset();

        // Random traffic.
        for (int j = 0; j < 400; j++) begin
            for (int i = 0; i < NCHAN; i++) begin
                re_buf[i] = int'($urandom_range(0, 2047)) - 1024;
                im_buf[i] = int'($urandom_range(0, 2047)) - 1024;
            end
            drive($urandom_range(0, 4) == 0, int'($urandom_range(0, 63)) - 32,
                  $urandom_range(0, 3) != 0);
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d beats still outstanding, expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cbfp_denorm_module.md
Name: cbfp_denorm_module

Overview:
- Inverse of the CBFP normalizer stage. Takes NCHAN complex samples per cycle in reduced-width block-floating-point form, plus one block exponent per block of BLK_BEATS beats.
- Re-expands each sample to full fixed-point width by undoing the per-block shift, with saturation.
- Sits at the tail of the FFT datapath, after the reorder stage. Exponents arrive ahead of, and decoupled from, their data blocks, so they are buffered in a small FIFO.

Parameters:
- IN_W, 11, input sample width (<5.6>).
- OUT_W, 23, output sample width (<10.13>).
- NCHAN, 16, complex samples per beat.
- BLK_BEATS, 4, beats sharing one exponent.
- EXP_W, 6, signed exponent width.
- BASE_SHIFT, 12, left shift applied when exponent = 0.
- FIFO_DEPTH, 8, exponent FIFO entries (power of 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- exp_valid  in  1  exp_in valid this cycle (push).
- exp_in  in  EXP_W signed  shift the normalizer applied to the block.
- valid_in  in  1  data beat valid.
- data_re_in  in  [NCHAN] x IN_W signed  real parts.
- data_im_in  in  [NCHAN] x IN_W signed  imaginary parts.
- data_re_out  out  [NCHAN] x OUT_W signed  de-normalized real parts.
- data_im_out  out  [NCHAN] x OUT_W signed  de-normalized imaginary parts.
- valid_out  out  1  output beat valid.
- sat_out  out  1  some lane of this output beat saturated.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  exponent FIFO occupancy.
- err_ovf  out  1  sticky: push while full, exponent dropped.
- err_unf  out  1  sticky: block start with no exponent available.

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, FIFO emptied, beat counter 0, pipeline valids cleared. A reset mid-block discards the partial block and all queued exponents.
- Beat counter:
  - Counts 0..BLK_BEATS-1 and advances only on valid_in=1.
  - Wraps to 0 after BLK_BEATS-1.
  - Gaps in valid_in hold the count; a block may span idle cycles.
- Exponent select:
  - On a valid beat with count=0, pop the FIFO head into cur_exp.
  - cur_exp is used for that beat and the following BLK_BEATS-1 valid beats.
- Bypass: if the FIFO is empty and exp_valid=1 on the same cycle as a count=0 beat, use exp_in directly; nothing is pushed and no error is raised.
- Underflow: FIFO empty, no bypass, count=0 beat → cur_exp=0, err_unf set, data still processed.
- Push while full:
  - With a simultaneous pop, the push is accepted (pop first).
  - Otherwise exp_in is dropped and err_ovf set.
- Error flags clear only on reset.
- Arithmetic:
  - net = BASE_SHIFT − cur_exp, computed at EXP_W+1 bits signed and clamped to [−(OUT_W−1), OUT_W−1].
  - x = sign-extend(in) to OUT_W.
  - net ≥ 0: x <<< net. If the result exceeds the OUT_W signed range, clamp to +(2^(OUT_W−1)−1) or −2^(OUT_W−1).
  - net < 0: x >>> −net (arithmetic, floor, no rounding).
  - Re and im lanes are processed identically and independently.
- Pipeline, latency 2 cycles from valid_in to valid_out:
  - Stage 1 registers the sign-extended data and net.
  - Stage 2 registers the shifted/saturated result, valid_out and sat_out.
- Full throughput: one beat per cycle, no backpressure.
- When valid_out=0, data outputs hold their last value; sat_out=0.
- fifo_level is updated registered, one cycle after the push/pop.

Decomposition:
- Package cbfp_pkg:
  - constants NCHAN, IN_W, OUT_W, EXP_W, BASE_SHIFT;
  - typedefs for the in-sample, out-sample and exponent types, plus the NCHAN array types;
  - shared by the normalizer and this block.
- Sub-module cbfp_exp_fifo:
  - synchronous FIFO, WIDTH=EXP_W, DEPTH=FIFO_DEPTH;
  - push/pop/full/empty/level ports.
- Shift/saturate logic stays inline as a per-lane generate loop.

Test Plan:
- Identity scale: push exp=0; 4 beats with all re=1, im=−1 → valid_out 2 cycles after each beat; re=4096, im=−4096; sat_out=0; err flags 0.
- Right shift: push exp=14 (net −2); re=5, im=−5 → re=1, im=−2.
- Saturation: push exp=−2 (net 14); re lane0=1023, others 0 → lane0=4194303, others 0, sat_out=1. Repeat with re=−1024 → −4194304.
- Exponent queueing with gaps: push 3, 0, 14 back-to-back; then 12 beats of re=−8 with one idle cycle every 3 beats → beats 0–3 give −4096, beats 4–7 give −32768, beats 8–11 give −2; fifo_level steps 3→2→1→0.
- Errors and bypass:
  - 9 pushes with no pops → err_ovf=1, level=8.
  - After reset, data beat with FIFO empty and no exp_valid → err_unf=1, output uses exp=0.
  - After reset, exp_valid with the first beat (exp=3) → net 9 applied, no error, level stays 0.
- Reset mid-block: push 2 exps, send 2 beats, assert rst 1 cycle → all outputs 0, level 0. The next beat is treated as count=0, and with no exponent pushed it raises err_unf.
